// File: rtl/fifo_wr_packer_if.sv
// Handshake and FIFO write-port bundle for fifo_wr_packer.
// The slave side is the packer; the master side is upstream logic and the FIFO.
interface fifo_wr_packer_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 4
);
  logic [IN_WIDTH-1:0]  s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic [OUT_WIDTH-1:0] fifo_wr_data;
  logic                 fifo_wr_en;
  logic                 fifo_full;

  modport slave (
    input  s_data, s_valid, fifo_full,
    output s_ready, fifo_wr_data, fifo_wr_en
  );

  modport master (
    output s_data, s_valid, fifo_full,
    input  s_ready, fifo_wr_data, fifo_wr_en
  );
endinterface

// File: rtl/fifo_wr_packer.sv
// Write-side width converter: splits IN_WIDTH words into OUT_WIDTH FIFO writes,
// stalling on fifo_full, with a wrapping word counter and a saturating stall counter.
module fifo_wr_packer #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 4,
  parameter int MSB_FIRST = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  wr_clk,
  input  logic                  wr_rstn,
  fifo_wr_packer_if.slave       bus,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);
  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = $clog2(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                state_r, state_s;
  logic [IN_WIDTH-1:0]   hold_r, hold_s;
  logic [IDX_W-1:0]      idx_r, idx_s;
  logic [CNT_WIDTH-1:0]  word_cnt_r, word_cnt_s;
  logic [CNT_WIDTH-1:0]  stall_cnt_r, stall_cnt_s;
  logic [IDX_W-1:0]      sel_s;
  logic                  busy_s;
  logic                  last_s;
  logic                  wr_en_s;

  // Registers for FSM state, held word, nibble index and statistics.
  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      state_r     <= IDLE;
      hold_r      <= {IN_WIDTH{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      word_cnt_r  <= {CNT_WIDTH{1'b0}};
      stall_cnt_r <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r     <= state_s;
      hold_r      <= hold_s;
      idx_r       <= idx_s;
      word_cnt_r  <= word_cnt_s;
      stall_cnt_r <= stall_cnt_s;
    end
  end

  // Handshake outputs and next-state logic; a last-nibble write may reload in the same edge.
  always_comb begin
    busy_s      = (state_r == SEND);
    last_s      = (idx_r == LAST_IDX);
    wr_en_s     = busy_s && !bus.fifo_full;
    state_s     = state_r;
    hold_s      = hold_r;
    idx_s       = idx_r;
    word_cnt_s  = word_cnt_r;
    stall_cnt_s = stall_cnt_r;

    case (state_r)
      IDLE: begin
        if (bus.s_valid) begin
          hold_s  = bus.s_data;
          idx_s   = {IDX_W{1'b0}};
          state_s = SEND;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (bus.fifo_full) begin
          if (stall_cnt_r != {CNT_WIDTH{1'b1}}) begin
            stall_cnt_s = stall_cnt_r + CNT_WIDTH'(1);
          end else begin
            stall_cnt_s = stall_cnt_r;
          end
        end else if (!last_s) begin
          idx_s = idx_r + IDX_W'(1);
        end else begin
          word_cnt_s = word_cnt_r + CNT_WIDTH'(1);
          if (bus.s_valid) begin
            hold_s  = bus.s_data;
            idx_s   = {IDX_W{1'b0}};
            state_s = SEND;
          end else begin
            state_s = IDLE;
          end
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Slice selection; MSB_FIRST walks the slices from the top down.
  always_comb begin
    if (MSB_FIRST != 0) begin
      sel_s = LAST_IDX - idx_r;
    end else begin
      sel_s = idx_r;
    end
    bus.fifo_wr_data = {OUT_WIDTH{1'b0}};
    for (int i = 0; i < RATIO; i++) begin
      if (sel_s == IDX_W'(i)) begin
        bus.fifo_wr_data = hold_r[i*OUT_WIDTH +: OUT_WIDTH];
      end else begin
        bus.fifo_wr_data = bus.fifo_wr_data;
      end
    end
  end

  // Drive the remaining outputs from state and the FIFO full flag.
  always_comb begin
    bus.fifo_wr_en = wr_en_s;
    bus.s_ready    = (state_r == IDLE) || (last_s && !bus.fifo_full);
    busy           = busy_s;
    word_cnt       = word_cnt_r;
    stall_cnt      = stall_cnt_r;
  end
endmodule

// File: tb/tb_fifo_wr_packer.sv
// Scoreboard bench: two packers (LSB-first with 4-bit counters, MSB-first with 16-bit
// counters) share stimulus; a negedge monitor pops expected nibbles on every write.
module tb_fifo_wr_packer;
  logic        wr_clk;
  logic        wr_rstn;
  logic [15:0] s_data;
  logic        s_valid;
  logic        fifo_full;
  logic        busy0, busy1;
  logic [3:0]  wc0, sc0;
  logic [15:0] wc1, sc1;
  int          checks;
  int          errors;
  logic [3:0]  q0[$];
  logic [3:0]  q1[$];

  fifo_wr_packer_if #(.IN_WIDTH(16), .OUT_WIDTH(4)) if0 ();
  fifo_wr_packer_if #(.IN_WIDTH(16), .OUT_WIDTH(4)) if1 ();

  assign if0.s_data    = s_data;
  assign if0.s_valid   = s_valid;
  assign if0.fifo_full = fifo_full;
  assign if1.s_data    = s_data;
  assign if1.s_valid   = s_valid;
  assign if1.fifo_full = fifo_full;

  fifo_wr_packer #(.IN_WIDTH(16), .OUT_WIDTH(4), .MSB_FIRST(0), .CNT_WIDTH(4)) dut0 (
    .wr_clk(wr_clk), .wr_rstn(wr_rstn), .bus(if0.slave),
    .busy(busy0), .word_cnt(wc0), .stall_cnt(sc0)
  );

  fifo_wr_packer #(.IN_WIDTH(16), .OUT_WIDTH(4), .MSB_FIRST(1), .CNT_WIDTH(16)) dut1 (
    .wr_clk(wr_clk), .wr_rstn(wr_rstn), .bus(if1.slave),
    .busy(busy1), .word_cnt(wc1), .stall_cnt(sc1)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every FIFO write must match the next expected nibble.
  always @(negedge wr_clk) begin
    if (if0.fifo_wr_en === 1'b1) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut0_extra_write: got %h expected no write at %0t", if0.fifo_wr_data, $time);
      end else begin
        chk("dut0_nibble", 32'(if0.fifo_wr_data), 32'(q0.pop_front()));
      end
    end
    if (if1.fifo_wr_en === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1_extra_write: got %h expected no write at %0t", if1.fifo_wr_data, $time);
      end else begin
        chk("dut1_nibble", 32'(if1.fifo_wr_data), 32'(q1.pop_front()));
      end
    end
  end

  task automatic push_word(input logic [15:0] d);
    for (int i = 0; i < 4; i++) begin
      q0.push_back(d[i*4 +: 4]);
      q1.push_back(d[(3-i)*4 +: 4]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_en0"}, 32'(if0.fifo_wr_en), 32'd0);
    chk({tag, "_wr_en1"}, 32'(if1.fifo_wr_en), 32'd0);
    chk({tag, "_busy0"}, 32'(busy0), 32'd0);
    chk({tag, "_ready0"}, 32'(if0.s_ready), 32'd1);
    chk({tag, "_data0"}, 32'(if0.fifo_wr_data), 32'd0);
    chk({tag, "_wc0"}, 32'(wc0), 32'd0);
    chk({tag, "_sc0"}, 32'(sc0), 32'd0);
    chk({tag, "_wc1"}, 32'(wc1), 32'd0);
  endtask

  task automatic do_reset();
    s_valid   = 1'b0;
    fifo_full = 1'b0;
    wr_rstn   = 1'b0;
    @(negedge wr_clk);
    check_reset_outputs("reset");
    @(posedge wr_clk);
    #1 wr_rstn = 1'b1;
  endtask

  // Present a word and wait for its accept edge; returns 1 time unit after that edge.
  task automatic send_word(input logic [15:0] d);
    logic ok;
    s_data  = d;
    s_valid = 1'b1;
    push_word(d);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge wr_clk);
      ok = if0.s_ready;
      @(posedge wr_clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no s_ready expected accept of %h", d);
    end
  endtask

  task automatic wait_idle(input string tag);
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 100 && !idle; i++) begin
      @(negedge wr_clk);
      idle = !busy0 && !busy1;
    end
    if (!idle) begin
      checks++;
      errors++;
      $display("FAIL %s_idle_timeout: got busy expected idle", tag);
    end
  endtask

  initial begin
    logic [15:0] words [3];
    checks    = 0;
    errors    = 0;
    wr_rstn   = 1'b0;
    s_valid   = 1'b0;
    s_data    = 16'h0000;
    fifo_full = 1'b0;
    repeat (2) @(posedge wr_clk);
    #1;

    // Single word: 3,C,5,A (dut1: A,5,C,3), busy drops right after the 4th write
    do_reset();
    send_word(16'hA5C3);
    s_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge wr_clk);
      chk("single_wr_en", 32'(if0.fifo_wr_en), 32'd1);
      chk("single_busy", 32'(busy0), 32'd1);
      @(posedge wr_clk);
      #1;
    end
    @(negedge wr_clk);
    chk("single_busy_drop", 32'(busy0), 32'd0);
    chk("single_wc0", 32'(wc0), 32'd1);
    chk("single_wc1", 32'(wc1), 32'd1);

    // Back-to-back: 12 consecutive writes, ready only on each 4th nibble
    do_reset();
    words[0] = 16'h1234;
    words[1] = 16'h5678;
    words[2] = 16'h9ABC;
    for (int w = 0; w < 3; w++) push_word(words[w]);
    s_data  = words[0];
    s_valid = 1'b1;
    @(negedge wr_clk);
    chk("b2b_first_ready", 32'(if0.s_ready), 32'd1);
    @(posedge wr_clk);
    #1 s_data = words[1];
    for (int i = 0; i < 12; i++) begin
      @(negedge wr_clk);
      chk("b2b_wr_en", 32'(if0.fifo_wr_en), 32'd1);
      chk("b2b_ready", 32'(if0.s_ready), ((i % 4) == 3) ? 32'd1 : 32'd0);
      @(posedge wr_clk);
      #1;
      if (i == 3) s_data = words[2];
      if (i == 7) s_valid = 1'b0;
    end
    wait_idle("b2b");
    chk("b2b_wc0", 32'(wc0), 32'd3);
    chk("b2b_wc1", 32'(wc1), 32'd3);

    // Back-pressure: full for 5 cycles from the 2nd nibble of BEEF
    do_reset();
    send_word(16'hBEEF);
    s_valid = 1'b0;
    @(posedge wr_clk);
    #1 fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge wr_clk);
      chk("bp_wr_en", 32'(if0.fifo_wr_en), 32'd0);
      chk("bp_ready", 32'(if0.s_ready), 32'd0);
      chk("bp_busy", 32'(busy0), 32'd1);
      @(posedge wr_clk);
      #1;
    end
    fifo_full = 1'b0;
    wait_idle("bp");
    chk("bp_sc0", 32'(sc0), 32'd5);
    chk("bp_sc1", 32'(sc1), 32'd5);
    chk("bp_wc0", 32'(wc0), 32'd1);

    // Reset mid-word after two nibbles, then a fresh word from nibble 0
    do_reset();
    send_word(16'h1357);
    s_valid = 1'b0;
    repeat (2) @(posedge wr_clk);
    #1 wr_rstn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    q0.delete();
    q1.delete();
    @(posedge wr_clk);
    #1 wr_rstn = 1'b1;
    send_word(16'h2468);
    s_valid = 1'b0;
    wait_idle("midrst");
    chk("midrst_wc0", 32'(wc0), 32'd1);

    // Saturation (4-bit stall counter) and wrap (17 words on a 4-bit word counter)
    do_reset();
    fifo_full = 1'b1;
    send_word(16'hCAFE);
    s_valid = 1'b0;
    repeat (20) @(posedge wr_clk);
    #1;
    chk("sat_sc0", 32'(sc0), 32'hF);
    chk("sat_sc1", 32'(sc1), 32'd20);
    fifo_full = 1'b0;
    for (int w = 0; w < 16; w++) send_word(16'h1111 * 16'(w));
    s_valid = 1'b0;
    wait_idle("wrap");
    chk("wrap_wc0", 32'(wc0), 32'd1);
    chk("wrap_wc1", 32'(wc1), 32'd17);
    chk("wrap_sc0_held", 32'(sc0), 32'hF);

    @(negedge wr_clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
